// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
//   run, opcode, mem_ready  : datapath/host -> sequencer
//   PCWrite .. PCSource     : sequencer -> datapath control lines
//   instr_done, instr_count : retire pulse and retired-instruction counter
//   error, state            : sticky illegal-opcode flag and debug state
// Modport master is the sequencer side, slave is the datapath/host side.
interface multicycle_control_fsm_if;
    logic        run;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemToReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic        instr_done;
    logic [31:0] instr_count;
    logic        error;
    logic [3:0]  state;

    modport master (
        input  run, opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, instr_count, error, state
    );

    modport slave (
        output run, opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, instr_count, error, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch / decode /
// execute / memory / write-back, stalls on mem_ready, counts retirements and
// traps illegal opcodes.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : control bundle (master side), see multicycle_control_fsm_if
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | parked, waits for run
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | compute branch target into ALU register
// MEMADR | effective address rs + imm
// MEMRD  | load data read, waits for mem_ready
// MEMWB  | load write-back (retire)
// MEMWR  | store write, retires on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back to rd (retire)
// BRANCH | beq compare, conditional PC load (retire)
// JUMP   | PC <- jump address (retire)
// ADDIEX | rs + sign-extended imm
// ADDIWB | addi write-back to rt (retire)
// ERROR  | illegal opcode trap, left only by reset
module multicycle_control_fsm (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ADDIEX = 4'd11,
        ADDIWB = 4'd12, ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      state_q, state_nxt;
    logic [31:0] count_r;
    logic        pc_write_r, pc_write_cond_r, ior_d_r, mem_read_r, mem_write_r;
    logic        mem_to_reg_r, reg_dst_r, reg_write_r, alu_src_a_r, error_r;
    logic [1:0]  alu_src_b_r, alu_op_r, pc_source_r;
    // State flags for the few outputs that are qualified by mem_ready.
    logic        fetch_r, memwr_r, retire_r;
    logic        done;

    assign done = retire_r | (memwr_r & bus.mem_ready);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:   if (bus.run) state_nxt = FETCH;
            FETCH:  if (bus.mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXEC;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_J:         state_nxt = JUMP;
                    OP_ADDI:      state_nxt = ADDIEX;
                    default:      state_nxt = ERROR;
                endcase
            end
            MEMADR: if (bus.opcode == OP_SW) state_nxt = MEMWR;
                    else                     state_nxt = MEMRD;
            MEMRD:  if (bus.mem_ready) state_nxt = MEMWB;
            MEMWR:  if (bus.mem_ready) begin
                        if (bus.run) state_nxt = FETCH;
                        else         state_nxt = IDLE;
                    end
            EXEC:   state_nxt = ALUWB;
            ADDIEX: state_nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: begin
                if (bus.run) state_nxt = FETCH;
                else         state_nxt = IDLE;
            end
            ERROR:  state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they change
    // cleanly on the clock edge that enters each state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            count_r         <= '0;
            error_r         <= 1'b0;
            pc_write_r      <= 1'b0;
            pc_write_cond_r <= 1'b0;
            ior_d_r         <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            reg_dst_r       <= 1'b0;
            reg_write_r     <= 1'b0;
            alu_src_a_r     <= 1'b0;
            alu_src_b_r     <= 2'b00;
            alu_op_r        <= 2'b00;
            pc_source_r     <= 2'b00;
            fetch_r         <= 1'b0;
            memwr_r         <= 1'b0;
            retire_r        <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            if (done) count_r <= count_r + 32'd1;
            error_r         <= error_r | (state_nxt == ERROR);
            pc_write_r      <= 1'b0;
            pc_write_cond_r <= 1'b0;
            ior_d_r         <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            reg_dst_r       <= 1'b0;
            reg_write_r     <= 1'b0;
            alu_src_a_r     <= 1'b0;
            alu_src_b_r     <= 2'b00;
            alu_op_r        <= 2'b00;
            pc_source_r     <= 2'b00;
            fetch_r         <= (state_nxt == FETCH);
            memwr_r         <= (state_nxt == MEMWR);
            retire_r        <= (state_nxt == MEMWB)  || (state_nxt == ALUWB) ||
                               (state_nxt == BRANCH) || (state_nxt == JUMP)  ||
                               (state_nxt == ADDIWB);
            case (state_nxt)
                FETCH:  begin mem_read_r <= 1'b1; alu_src_b_r <= 2'b01; end
                DECODE: alu_src_b_r <= 2'b11;
                MEMADR: begin alu_src_a_r <= 1'b1; alu_src_b_r <= 2'b10; end
                MEMRD:  begin mem_read_r <= 1'b1; ior_d_r <= 1'b1; end
                MEMWB:  begin mem_to_reg_r <= 1'b1; reg_write_r <= 1'b1; end
                MEMWR:  begin mem_write_r <= 1'b1; ior_d_r <= 1'b1; end
                EXEC:   begin alu_src_a_r <= 1'b1; alu_op_r <= 2'b10; end
                ALUWB:  begin reg_dst_r <= 1'b1; reg_write_r <= 1'b1; end
                BRANCH: begin
                    alu_src_a_r     <= 1'b1;
                    alu_op_r        <= 2'b01;
                    pc_write_cond_r <= 1'b1;
                    pc_source_r     <= 2'b01;
                end
                JUMP:   begin pc_write_r <= 1'b1; pc_source_r <= 2'b10; end
                ADDIEX: begin alu_src_a_r <= 1'b1; alu_src_b_r <= 2'b10; end
                ADDIWB: reg_write_r <= 1'b1;
                default: ;
            endcase
        end
    end

    // PC increment and IR load happen only on the fetch cycle that completes.
    assign bus.PCWrite     = pc_write_r | (fetch_r & bus.mem_ready);
    assign bus.IRWrite     = fetch_r & bus.mem_ready;
    assign bus.PCWriteCond = pc_write_cond_r;
    assign bus.IorD        = ior_d_r;
    assign bus.MemRead     = mem_read_r;
    assign bus.MemWrite    = mem_write_r;
    assign bus.MemToReg    = mem_to_reg_r;
    assign bus.RegDst      = reg_dst_r;
    assign bus.RegWrite    = reg_write_r;
    assign bus.ALUSrcA     = alu_src_a_r;
    assign bus.ALUSrcB     = alu_src_b_r;
    assign bus.ALUOp       = alu_op_r;
    assign bus.PCSource    = pc_source_r;
    assign bus.instr_done  = done;
    assign bus.instr_count = count_r;
    assign bus.error       = error_r;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                           S_MEMWR = 4'd6, S_EXEC = 4'd7, S_ALUWB = 4'd8,
                           S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                           S_ADDIWB = 4'd12, S_ERROR = 4'd15;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ILL = 6'b111111;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc_no;
    int   ir_pulses;
    logic [3:0] tr_st [23];
    logic [5:0] tr_op [23];

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected control vector:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, op, ps;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1'b1; sb = 2'b01; pcw = mr; irw = mr; end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
            S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
            S_EXEC:   begin sa = 1'b1; op = 2'b10; end
            S_ALUWB:  begin rdst = 1'b1; rw = 1'b1; end
            S_BRANCH: begin sa = 1'b1; op = 2'b01; pcwc = 1'b1; ps = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; ps = 2'b10; end
            S_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            S_ADDIWB: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, ps};
    endfunction

    function automatic logic exp_done(input logic [3:0] st, input logic mr);
        case (st)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: return 1'b1;
            S_MEMWR: return mr;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_cycle(input string tag, input logic [3:0] st);
        logic [15:0] ctl;
        ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
               bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
               bus.ALUSrcB, bus.ALUOp, bus.PCSource};
        check_val({tag, ".state"}, 32'(bus.state), 32'(st));
        check_val({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl(st, bus.mem_ready)));
        check_val({tag, ".done"}, 32'(bus.instr_done), 32'(exp_done(st, bus.mem_ready)));
        check_val({tag, ".error"}, 32'(bus.error), 32'(st == S_ERROR));
    endtask

    // One clock: drive inputs on the falling edge, check the current state
    // shortly after.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic rn, input logic [3:0] st);
        @(negedge clock);
        bus.opcode    = op;
        bus.mem_ready = mr;
        bus.run       = rn;
        #1;
        cyc_no++;
        check_cycle($sformatf("c%0d", cyc_no), st);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc_no    = 0;
        ir_pulses = 0;
        tr_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
                  S_FETCH, S_DECODE, S_MEMADR, S_MEMWR,
                  S_FETCH, S_DECODE, S_EXEC, S_ALUWB,
                  S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB,
                  S_FETCH, S_DECODE, S_BRANCH,
                  S_FETCH, S_DECODE, S_JUMP};
        tr_op = '{OP_LW, OP_LW, OP_LW, OP_LW, OP_LW,
                  OP_SW, OP_SW, OP_SW, OP_SW,
                  OP_R, OP_R, OP_R, OP_R,
                  OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                  OP_BEQ, OP_BEQ, OP_BEQ,
                  OP_J, OP_J, OP_J};

        reset         = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b0;
        #6;
        check_cycle("reset", S_IDLE);
        check_val("reset.count", bus.instr_count, 32'd0);

        // Zero-wait instruction mix.
        @(negedge clock);
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_LW;
        for (int i = 0; i < 23; i++) cyc(tr_op[i], 1'b1, 1'b1, tr_st[i]);

        // Fetch stalled for three cycles.
        for (int k = 0; k < 4; k++) begin
            cyc(OP_R, (k == 3), 1'b1, S_FETCH);
            if (k == 0) check_val("mix.count", bus.instr_count, 32'd6);
            if (bus.IRWrite) ir_pulses++;
        end
        check_val("stall.ir_pulses", 32'(ir_pulses), 32'd1);

        // run dropped during EXEC: instruction completes, then park.
        cyc(OP_R, 1'b1, 1'b1, S_DECODE);
        cyc(OP_R, 1'b1, 1'b0, S_EXEC);
        cyc(OP_R, 1'b1, 1'b0, S_ALUWB);
        cyc(OP_R, 1'b1, 1'b0, S_IDLE);
        check_val("park.count", bus.instr_count, 32'd7);

        // Store with two wait cycles in MEMWR.
        cyc(OP_SW, 1'b1, 1'b1, S_IDLE);
        cyc(OP_SW, 1'b1, 1'b1, S_FETCH);
        cyc(OP_SW, 1'b1, 1'b1, S_DECODE);
        cyc(OP_SW, 1'b1, 1'b1, S_MEMADR);
        cyc(OP_SW, 1'b0, 1'b1, S_MEMWR);
        cyc(OP_SW, 1'b0, 1'b1, S_MEMWR);
        cyc(OP_SW, 1'b1, 1'b1, S_MEMWR);
        cyc(OP_R, 1'b1, 1'b1, S_FETCH);
        check_val("sw.count", bus.instr_count, 32'd8);

        // Counter wrap.
        cyc(OP_R, 1'b1, 1'b1, S_DECODE);
        force dut.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.count_r;
        cyc(OP_R, 1'b1, 1'b1, S_EXEC);
        check_val("wrap.pre", bus.instr_count, 32'hFFFF_FFFF);
        cyc(OP_R, 1'b1, 1'b1, S_ALUWB);
        cyc(OP_ILL, 1'b1, 1'b1, S_FETCH);
        check_val("wrap.post", bus.instr_count, 32'd0);

        // Illegal opcode trap, run toggling has no effect.
        cyc(OP_ILL, 1'b1, 1'b1, S_DECODE);
        cyc(OP_ILL, 1'b1, 1'b0, S_ERROR);
        cyc(OP_ILL, 1'b1, 1'b1, S_ERROR);
        cyc(OP_ILL, 1'b1, 1'b0, S_ERROR);
        cyc(OP_LW, 1'b1, 1'b1, S_ERROR);
        check_val("trap.count", bus.instr_count, 32'd0);

        // Asynchronous reset clears the trap.
        #2;
        reset = 1'b0;
        #1;
        check_cycle("rst_err", S_IDLE);

        // Reset while a load read is stalled.
        @(negedge clock);
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_LW;
        cyc(OP_LW, 1'b1, 1'b1, S_FETCH);
        cyc(OP_LW, 1'b1, 1'b1, S_DECODE);
        cyc(OP_LW, 1'b1, 1'b1, S_MEMADR);
        cyc(OP_LW, 1'b0, 1'b1, S_MEMRD);
        cyc(OP_LW, 1'b0, 1'b1, S_MEMRD);
        #2;
        reset = 1'b0;
        #1;
        check_val("rst_memrd.memread", 32'(bus.MemRead), 32'd0);
        check_cycle("rst_memrd", S_IDLE);
        check_val("rst_memrd.count", bus.instr_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc(OP_LW, 1'b1, 1'b1, S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
